// File: rtl/mda_pkg.sv
// Shared constants and state encoding for the MDA character/attribute RAM arbiter.
package mda_pkg;
  localparam int          COLS     = 80;
  localparam int          ROWS     = 25;
  localparam int          CELLS    = COLS * ROWS;
  localparam int          AW       = 11;
  localparam logic [15:0] CLR_WORD = 16'h0720;

  typedef enum logic [1:0] {IDLE, HACK, CLEAR} state_e;
endpackage

// File: rtl/mda_cell_addr.sv
// Linear cell address from character position: row*80 + col.
module mda_cell_addr
  import mda_pkg::*;
(
  input  logic [6:0]    col,
  input  logic [4:0]    row,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] r, c;

  assign r = AW'(row);
  assign c = AW'(col);
  // 80 = 64 + 16
  assign addr = (r << 6) + (r << 4) + c;
endmodule

// File: rtl/mda_vram_arb.sv
// Single-port VRAM arbiter: display fetch first, host port and clear engine on free cycles.
module mda_vram_arb
  import mda_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [6:0]    disp_col,
  input  logic [4:0]    disp_row,
  output logic [7:0]    disp_code,
  output logic [7:0]    disp_attr,
  output logic          disp_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [15:0]   host_wdata,
  output logic [15:0]   host_rdata,
  output logic          host_ack,
  output logic          host_err,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata
);
  localparam logic [AW-1:0] NCELL = AW'(CELLS);
  localparam logic [AW-1:0] LAST  = AW'(CELLS - 1);

  state_e        state;
  logic [AW-1:0] clr_cnt, disp_addr;
  logic [1:0]    vld_pipe;
  logic          clr_pend, h_rd, h_err;
  logic          free, h_inrange, clr_req, clr_go, h_go, clr_wr;

  mda_cell_addr u_addr (.col(disp_col), .row(disp_row), .addr(disp_addr));

  assign free      = !disp_req;
  assign h_inrange = host_addr < NCELL;
  // a start that lands on a display cycle is remembered so it is not lost
  assign clr_req   = clr_start | clr_pend;
  assign clr_go    = free && (state == IDLE) && clr_req;
  assign h_go      = free && (state == IDLE) && !clr_req && host_req;
  assign clr_wr    = free && (state == CLEAR);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (disp_req) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (h_go && h_inrange) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (clr_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = CLR_WORD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      clr_pend  <= 1'b0;
      h_rd      <= 1'b0;
      h_err     <= 1'b0;
      vld_pipe  <= '0;
      disp_code <= '0;
      disp_attr <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], disp_req};
      if (vld_pipe[0]) {disp_attr, disp_code} <= ram_rdata;

      if (clr_go)                          clr_pend <= 1'b0;
      else if (clr_start && state != CLEAR) clr_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (clr_go) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (h_go) begin
            state <= HACK;
            h_rd  <= h_inrange && !host_we;
            h_err <= !h_inrange;
          end
        end
        HACK: begin
          state <= IDLE;
          h_rd  <= 1'b0;
          h_err <= 1'b0;
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_cnt == LAST) begin
              state   <= IDLE;
              clr_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign disp_valid = vld_pipe[1];
  assign host_ack   = (state == HACK);
  assign host_err   = h_err;
  assign host_rdata = h_rd ? ram_rdata : 16'h0000;
  assign clr_busy   = (state == CLEAR);
endmodule

// File: tb/tb_mda_vram_arb.sv
// Directed bench for mda_vram_arb with a behavioural synchronous RAM attached.
module tb_mda_vram_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [6:0]  disp_col = '0;
  logic [4:0]  disp_row = '0;
  logic [7:0]  disp_code, disp_attr;
  logic        disp_valid;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [10:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic [15:0] host_rdata;
  logic        host_ack, host_err;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  logic [15:0] mem [0:2047];
  logic        preload = 1'b1;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mda_vram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_col(disp_col), .disp_row(disp_row),
    .disp_code(disp_code), .disp_attr(disp_attr), .disp_valid(disp_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err), .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM model: one-cycle synchronous read; preload happens in the same process
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] = 16'(i);
      mem[1999] = 16'h1E3C;
      mem[80]   = 16'h7055;
      mem[3]    = 16'h2233;
      preload   = 1'b0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // drives request at posedge+1, returns with outputs sampled at posedge+2 of the ack cycle
  task automatic host_xfer(input logic we, input logic [10:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output logic er, output logic en0,
                           output int lat);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    #1;
    en0 = ram_en;
    lat = 0;
    while (!host_ack && lat < 3000) begin
      @(posedge clk); #2;
      lat++;
    end
    rd = host_rdata;
    er = host_err;
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    vecs++;
    if ({disp_code, disp_attr, disp_valid, host_rdata, host_ack, host_err, clr_busy} !== '0) begin
      errs++;
      $display("FAIL reset_outs got %h/%h/%b/%h/%b/%b/%b required all 0",
               disp_code, disp_attr, disp_valid, host_rdata, host_ack, host_err, clr_busy);
    end
    vecs++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      errs++;
      $display("FAIL reset_ram got en=%b we=%b a=%0d wd=%h required 0", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch(input logic [6:0] col, input logic [4:0] row,
                       input logic [10:0] exp_addr, input logic [15:0] exp_word);
    @(posedge clk); #1;
    disp_req = 1'b1; disp_col = col; disp_row = row;
    #1;
    vecs++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== exp_addr) begin
      errs++;
      $display("FAIL disp_addr got en=%b we=%b a=%0d required 1 0 %0d", ram_en, ram_we, ram_addr, exp_addr);
    end
    @(posedge clk); #1;
    disp_req = 1'b0;
    #1;
    vecs++;
    if (disp_valid !== 1'b0) begin
      errs++;
      $display("FAIL disp_valid_early got %b required 0", disp_valid);
    end
    @(posedge clk); #2;
    vecs++;
    if (disp_valid !== 1'b1 || {disp_attr, disp_code} !== exp_word) begin
      errs++;
      $display("FAIL disp_data got v=%b %h required v=1 %h", disp_valid, {disp_attr, disp_code}, exp_word);
    end
    @(posedge clk); #2;
    vecs++;
    if (disp_valid !== 1'b0 || {disp_attr, disp_code} !== exp_word) begin
      errs++;
      $display("FAIL disp_hold got v=%b %h required v=0 %h", disp_valid, {disp_attr, disp_code}, exp_word);
    end
  endtask

  task automatic test_display;
    fetch(7'd79, 5'd24, 11'd1999, 16'h1E3C);
    fetch(7'd0,  5'd1,  11'd80,   16'h7055);
  endtask

  task automatic test_host_wr_rd;
    logic [15:0] rd; logic er, en0; int lat;
    host_xfer(1'b1, 11'd5, 16'h0F41, rd, er, en0, lat);
    vecs++;
    if (lat != 1 || er !== 1'b0 || en0 !== 1'b1) begin
      errs++;
      $display("FAIL host_write got lat=%0d err=%b en=%b required 1 0 1", lat, er, en0);
    end
    host_xfer(1'b0, 11'd5, 16'h0000, rd, er, en0, lat);
    vecs++;
    if (lat != 1 || er !== 1'b0 || rd !== 16'h0F41) begin
      errs++;
      $display("FAIL host_read got lat=%0d err=%b rd=%h required 1 0 0f41", lat, er, rd);
    end
  endtask

  task automatic test_collision;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    disp_req = 1'b1; disp_col = 7'd3; disp_row = 5'd0;
    #1;
    vecs++;
    if (ram_addr !== 11'd3 || ram_we !== 1'b0 || host_ack !== 1'b0) begin
      errs++;
      $display("FAIL coll_disp got a=%0d we=%b ack=%b required 3 0 0", ram_addr, ram_we, host_ack);
    end
    @(posedge clk); #1;
    disp_req = 1'b0;
    #1;
    vecs++;
    if (ram_en !== 1'b1 || ram_addr !== 11'd5 || host_ack !== 1'b0) begin
      errs++;
      $display("FAIL coll_accept got en=%b a=%0d ack=%b required 1 5 0", ram_en, ram_addr, host_ack);
    end
    @(posedge clk); #2;
    vecs++;
    if (host_ack !== 1'b1 || host_rdata !== 16'h0F41 || host_err !== 1'b0) begin
      errs++;
      $display("FAIL coll_ack got ack=%b rd=%h err=%b required 1 0f41 0", host_ack, host_rdata, host_err);
    end
    vecs++;
    if (disp_valid !== 1'b1 || {disp_attr, disp_code} !== 16'h2233) begin
      errs++;
      $display("FAIL coll_disp_data got v=%b %h required 1 2233", disp_valid, {disp_attr, disp_code});
    end
    host_req = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [15:0] rd; logic er, en0; int lat;
    host_xfer(1'b0, 11'd2000, 16'h0000, rd, er, en0, lat);
    vecs++;
    if (lat != 1 || er !== 1'b1 || en0 !== 1'b0 || rd !== 16'h0000) begin
      errs++;
      $display("FAIL oor_read got lat=%0d err=%b en=%b rd=%h required 1 1 0 0000", lat, er, en0, rd);
    end
    @(posedge clk); #2;
    vecs++;
    if (host_ack !== 1'b0 || host_err !== 1'b0) begin
      errs++;
      $display("FAIL oor_after got ack=%b err=%b required 0 0", host_ack, host_err);
    end
  endtask

  task automatic test_clear;
    int writes = 0, bad = 0, ack_busy = 0, cyc = 1, wait_n = 0;
    logic seen_ack = 1'b0;
    logic [15:0] rd = '0;
    @(posedge clk); #1;
    clr_start = 1'b1;
    #1;
    vecs++;
    if (clr_busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_busy_start got %b required 0", clr_busy);
    end
    @(posedge clk); #1;
    clr_start = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    #1;
    vecs++;
    if (clr_busy !== 1'b1) begin
      errs++;
      $display("FAIL clr_busy_on got %b required 1", clr_busy);
    end
    while (clr_busy && cyc < 4000) begin
      if (ram_en && ram_we) begin
        if (ram_addr !== 11'(writes) || ram_wdata !== 16'h0720) bad++;
        writes++;
      end
      if (host_ack) ack_busy++;
      @(posedge clk); #1;
      disp_req = (cyc % 9 == 0);
      disp_col = 7'(cyc % 80); disp_row = 5'd0;
      cyc++;
      #1;
    end
    disp_req = 1'b0;
    vecs++;
    if (writes != 2000 || bad != 0) begin
      errs++;
      $display("FAIL clr_writes got %0d writes %0d bad required 2000 0", writes, bad);
    end
    vecs++;
    if (ack_busy != 0) begin
      errs++;
      $display("FAIL clr_host_stall got %0d acks while busy required 0", ack_busy);
    end
    while (!seen_ack && wait_n < 5) begin
      if (host_ack) begin seen_ack = 1'b1; rd = host_rdata; end
      else begin @(posedge clk); #2; wait_n++; end
    end
    host_req = 1'b0;
    vecs++;
    if (!seen_ack || rd !== 16'h0720) begin
      errs++;
      $display("FAIL clr_host_after got ack=%b rd=%h required 1 0720", seen_ack, rd);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [15:0] rd; logic er, en0; int lat;
    host_xfer(1'b1, 11'd1999, 16'hBEEF, rd, er, en0, lat);
    host_xfer(1'b1, 11'd10,   16'h1111, rd, er, en0, lat);
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    vecs++;
    if (clr_busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_clear_busy got %b required 1", clr_busy);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({disp_valid, host_ack, host_err, host_rdata, clr_busy, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      errs++;
      $display("FAIL mid_clear_reset got busy=%b en=%b we=%b a=%0d ack=%b", clr_busy, ram_en, ram_we, ram_addr, host_ack);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    host_xfer(1'b0, 11'd1999, 16'h0000, rd, er, en0, lat);
    vecs++;
    if (rd !== 16'hBEEF || er !== 1'b0) begin
      errs++;
      $display("FAIL rst_keep_1999 got rd=%h err=%b required beef 0", rd, er);
    end
    host_xfer(1'b0, 11'd10, 16'h0000, rd, er, en0, lat);
    vecs++;
    if (rd !== 16'h0720) begin
      errs++;
      $display("FAIL rst_cleared_10 got rd=%h required 0720", rd);
    end
  endtask

  initial begin
    test_reset;
    test_display;
    test_host_wr_rd;
    test_collision;
    test_out_of_range;
    test_clear;
    test_reset_mid_clear;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
